// File: rtl/alarm_pkg.sv
// alarm_pkg: shared types and timing constants for the alarm system blocks.
//   state_t       - pulse stretcher FSM encoding (IDLE / ON / OFF)
//   SYS_CLK_HZ    - nominal system clock frequency
//   BEEP_*_CYCLES - default buzzer beep on/off durations in clock cycles
//   ms_to_cycles  - converts a millisecond duration to clock cycles
package alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_t;

  localparam int unsigned SYS_CLK_HZ  = 50_000_000;
  localparam int unsigned BEEP_ON_MS  = 100;
  localparam int unsigned BEEP_OFF_MS = 150;

  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

  localparam int unsigned BEEP_ON_CYCLES  = ms_to_cycles(SYS_CLK_HZ, BEEP_ON_MS);
  localparam int unsigned BEEP_OFF_CYCLES = ms_to_cycles(SYS_CLK_HZ, BEEP_OFF_MS);

endpackage

// File: rtl/pulse_stretcher_if.sv
// pulse_stretcher_if: trigger/control and waveform status bundle.
//   i_trigger - single-cycle start pulse
//   i_count   - number of bursts (REP_W bits), sampled with i_trigger
//   i_abort   - stop immediately, no done pulse
//   o_level   - stretched waveform
//   o_busy    - sequence in progress
//   o_done    - one-cycle pulse after normal completion
// master: drives controls (system/testbench); slave: the stretcher.
interface pulse_stretcher_if #(
  parameter int unsigned REP_W = 4
);

  logic             i_trigger;
  logic [REP_W-1:0] i_count;
  logic             i_abort;
  logic             o_level;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_trigger, i_count, i_abort,
    input  o_level, o_busy, o_done
  );

  modport slave (
    input  i_trigger, i_count, i_abort,
    output o_level, o_busy, o_done
  );

endinterface

// File: rtl/pulse_stretcher_duration_counter.sv
// duration_counter: loadable down-counter that stops at zero.
//   clk        - clock
//   rst        - synchronous active-high reset, clears the count
//   load       - load load_value this cycle (wins over counting)
//   load_value - value loaded on load
//   tc         - terminal count, high while the count is zero
module duration_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_value;
    end else if (cnt != '0) begin
      cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns a single-cycle trigger into a burst waveform of
// i_count high periods (ON_CYCLES each) separated by low gaps (OFF_CYCLES).
//   i_clk - system clock
//   i_rst - synchronous active-high reset
//   bus   - pulse_stretcher_if slave: i_trigger, i_count, i_abort in;
//           o_level, o_busy, o_done out (all registered)
// Priority: reset > abort > trigger > normal counting.
module pulse_stretcher
  import alarm_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 3,
  parameter int unsigned OFF_CYCLES = 2,
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned REP_W      = 4,
  parameter bit          RETRIGGER  = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst,
  pulse_stretcher_if.slave  bus
);

  // The counter runs from N-1 down to 0, so a period lasts exactly N cycles
  // with the transition taken on the terminal-count cycle.
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);

  state_t           state, state_next;
  logic [REP_W-1:0] burst, burst_next;
  logic [REP_W-1:0] count_in;
  logic             count_nz;
  logic             start;
  logic             load;
  logic [CNT_W-1:0] load_value;
  logic             tc;
  logic             done_next;
  logic             level_q, busy_q, done_q;

  assign count_in = bus.i_count;
  assign count_nz = (count_in != '0);
  // Start from idle always; while busy only when retriggering is enabled.
  assign start    = bus.i_trigger && count_nz &&
                    ((state == ST_IDLE) || RETRIGGER);

  duration_counter #(
    .CNT_W (CNT_W)
  ) u_dur (
    .clk        (i_clk),
    .rst        (i_rst),
    .load       (load),
    .load_value (load_value),
    .tc         (tc)
  );

  always_comb begin
    state_next = state;
    burst_next = burst;
    load       = 1'b0;
    load_value = ON_LOAD;
    done_next  = 1'b0;
    if (bus.i_abort) begin
      state_next = ST_IDLE;
      burst_next = '0;
    end else if (start) begin
      state_next = ST_ON;
      burst_next = count_in;
      load       = 1'b1;
      load_value = ON_LOAD;
    end else begin
      unique case (state)
        ST_ON: begin
          if (tc) begin
            if (burst > REP_W'(1)) begin
              burst_next = burst - REP_W'(1);
              state_next = ST_OFF;
              load       = 1'b1;
              load_value = OFF_LOAD;
            end else begin
              burst_next = '0;
              state_next = ST_IDLE;
              done_next  = 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (tc) begin
            state_next = ST_ON;
            load       = 1'b1;
            load_value = ON_LOAD;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with the
  // state register instead of lagging it by a cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      burst   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_next;
      burst   <= burst_next;
      level_q <= (state_next == ST_ON);
      busy_q  <= (state_next != ST_IDLE);
      done_q  <= done_next;
    end
  end

  assign bus.o_level = level_q;
  assign bus.o_busy  = busy_q;
  assign bus.o_done  = done_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: drives two stretchers (RETRIGGER=1 and RETRIGGER=0,
// ON=3, OFF=2) with identical stimulus. Cycle c runs from posedge c to
// posedge c+1; outputs are sampled and inputs driven at the negedge of c.
// Expected {level,busy,done} for cycle c+1 is pushed when cycle c stimulus
// is driven and popped when cycle c+1 is sampled.
module tb_pulse_stretcher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pulse_stretcher_if #(.REP_W(4)) bus1 ();
  pulse_stretcher_if #(.REP_W(4)) bus0 ();

  pulse_stretcher #(
    .ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(24), .REP_W(4), .RETRIGGER(1'b1)
  ) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  pulse_stretcher #(
    .ON_CYCLES(3), .OFF_CYCLES(2), .CNT_W(24), .REP_W(4), .RETRIGGER(1'b0)
  ) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(bus0)
  );

  logic [2:0]  exp1[$];
  logic [2:0]  exp0[$];
  int unsigned passed = 0;
  int unsigned total  = 0;

  function automatic logic in_win(input int c, input int a, input int b);
    return (c >= a) && (c <= b);
  endfunction

  task automatic drive(input logic r, input logic trig, input logic [3:0] cnt,
                       input logic abrt);
    rst = r;
    bus1.i_trigger = trig; bus1.i_count = cnt; bus1.i_abort = abrt;
    bus0.i_trigger = trig; bus0.i_count = cnt; bus0.i_abort = abrt;
  endtask

  task automatic push_exp(input logic [2:0] v1, input logic [2:0] v0);
    exp1.push_back(v1);
    exp0.push_back(v0);
  endtask

  // Reset with a trigger applied during reset, then 10+ idle cycles.
  task automatic test_reset();
    logic [2:0] e1, e0, o1, o0;
    exp1.delete(); exp0.delete();
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (exp1.size() != 0) begin
        e1 = exp1.pop_front(); e0 = exp0.pop_front();
        o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
        o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
        total++;
        if (o1 !== e1) $display("FAIL reset rt1 c%0d lbd got %b want %b", c, o1, e1);
        else passed++;
        total++;
        if (o0 !== e0) $display("FAIL reset rt0 c%0d lbd got %b want %b", c, o0, e0);
        else passed++;
      end
      drive(c < 3, c == 2, 4'd5, 1'b0);
      push_exp(3'b000, 3'b000);
    end
  endtask

  // count=2 trigger at 0: high 1-3 and 6-8, busy 1-8, done at 9.
  task automatic test_basic();
    logic [2:0] e1, e0, o1, o0, v;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL basic rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL basic rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(1'b0, c == 0, 4'd2, 1'b0);
      k = c + 1;
      v = {in_win(k, 1, 3) || in_win(k, 6, 8), in_win(k, 1, 8), k == 9};
      push_exp(v, v);
    end
  endtask

  // Zero count from idle ignored; zero count while busy ignored (both modes).
  task automatic test_zero_count();
    logic [2:0] e1, e0, o1, o0, v;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL zero_count rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL zero_count rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(1'b0, (c == 0) || (c == 8) || (c == 10), (c == 8) ? 4'd1 : 4'd0, 1'b0);
      k = c + 1;
      v = {in_win(k, 9, 11), in_win(k, 9, 11), k == 12};
      push_exp(v, v);
    end
  endtask

  // Abort mid-OFF; abort beating a retrigger; abort beating an idle trigger.
  task automatic test_abort();
    logic [2:0] e1, e0, o1, o0, v;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL abort rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL abort rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(1'b0, (c == 0) || (c == 10) || (c == 13) || (c == 17), 4'd2,
            (c == 5) || (c == 13) || (c == 17));
      k = c + 1;
      v = {in_win(k, 1, 3) || in_win(k, 11, 13),
           in_win(k, 1, 5) || in_win(k, 11, 13), 1'b0};
      push_exp(v, v);
    end
  endtask

  // count=1 retriggered at 2 (mid-ON) and at 13 (terminal-count cycle).
  task automatic test_retrigger();
    logic [2:0] e1, e0, o1, o0, v1, v0;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL retrigger rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL retrigger rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(1'b0, (c == 0) || (c == 2) || (c == 10) || (c == 13), 4'd1, 1'b0);
      k = c + 1;
      v1 = {in_win(k, 1, 5) || in_win(k, 11, 16),
            in_win(k, 1, 5) || in_win(k, 11, 16), (k == 6) || (k == 17)};
      v0 = {in_win(k, 1, 3) || in_win(k, 11, 13),
            in_win(k, 1, 3) || in_win(k, 11, 13), (k == 4) || (k == 14)};
      push_exp(v1, v0);
    end
  endtask

  // Trigger in the done cycle, then a three-burst sequence.
  task automatic test_back_to_back();
    logic [2:0] e1, e0, o1, o0, v;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL back_to_back rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL back_to_back rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(1'b0, (c == 0) || (c == 4) || (c == 10), (c == 10) ? 4'd3 : 4'd1, 1'b0);
      k = c + 1;
      v = {in_win(k, 1, 3) || in_win(k, 5, 7) || in_win(k, 11, 13) ||
           in_win(k, 16, 18) || in_win(k, 21, 23),
           in_win(k, 1, 3) || in_win(k, 5, 7) || in_win(k, 11, 23),
           (k == 4) || (k == 8) || (k == 24)};
      push_exp(v, v);
    end
  endtask

  // Reset mid-ON clears everything; a following count=2 sequence is intact.
  task automatic test_reset_mid();
    logic [2:0] e1, e0, o1, o0, v;
    int k;
    exp1.delete(); exp0.delete();
    push_exp(3'b000, 3'b000);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      e1 = exp1.pop_front(); e0 = exp0.pop_front();
      o1 = {bus1.o_level, bus1.o_busy, bus1.o_done};
      o0 = {bus0.o_level, bus0.o_busy, bus0.o_done};
      total++;
      if (o1 !== e1) $display("FAIL reset_mid rt1 c%0d lbd got %b want %b", c, o1, e1);
      else passed++;
      total++;
      if (o0 !== e0) $display("FAIL reset_mid rt0 c%0d lbd got %b want %b", c, o0, e0);
      else passed++;
      drive(c == 2, (c == 0) || (c == 5), (c == 0) ? 4'd3 : 4'd2, 1'b0);
      k = c + 1;
      v = {in_win(k, 1, 2) || in_win(k, 6, 8) || in_win(k, 11, 13),
           in_win(k, 1, 2) || in_win(k, 6, 13), k == 14};
      push_exp(v, v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    drive(1'b1, 1'b0, 4'd0, 1'b0);
    test_reset();
    test_basic();
    test_zero_count();
    test_abort();
    test_retrigger();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
